// File: rtl/reg_xfer_ctrl.sv
// Register-transfer controller: moves an immediate, IN_PORT or register A/B value (optionally
// plus an immediate) into A and/or B. Define REG_XFER_CARRY_EN to enable the add path and CARRY.
module reg_xfer_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic [1:0] CMD_SRC,
   input  logic [1:0] CMD_DST,
   input  logic       CMD_ADD,
   input  logic [3:0] CMD_IMM,
   input  logic [3:0] IN_PORT,
   input  logic [3:0] A_LOADDATA,
   input  logic [3:0] B_LOADDATA,
   output logic       nA_OUT,
   output logic       nB_OUT,
   output logic       nA_ST,
   output logic       nB_ST,
   output logic [3:0] STOREDATA,
   output logic       CARRY,
   output logic       DONE
);

`ifdef REG_XFER_CARRY_EN
   localparam bit CarryEn = 1'b1;
`else
   localparam bit CarryEn = 1'b0;
`endif

   localparam logic [1:0] SrcImm = 2'b00;
   localparam logic [1:0] SrcA   = 2'b01;
   localparam logic [1:0] SrcB   = 2'b10;
   localparam logic [1:0] SrcIn  = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StCalc,
      StWrite,
      StFin
   } state_e;

   state_e     state_q;
   logic [1:0] src_q;
   logic [1:0] dst_q;
   logic       add_q;
   logic [3:0] imm_q;
   logic [3:0] opnd_q;
   logic       na_out_q;
   logic       nb_out_q;
   logic       na_st_q;
   logic       nb_st_q;
   logic [3:0] storedata_q;
   logic       carry_q;
   logic       done_q;

   logic       add_applied;
   logic [4:0] sum;

   // An immediate source is the value itself; the add flag only applies to the other sources.
   assign add_applied = CarryEn && add_q && (src_q != SrcImm);
   assign sum         = {1'b0, opnd_q} + {1'b0, (add_applied ? imm_q : 4'h0)};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= StIdle;
         src_q       <= SrcImm;
         dst_q       <= 2'b00;
         add_q       <= 1'b0;
         imm_q       <= 4'h0;
         opnd_q      <= 4'h0;
         na_out_q    <= 1'b1;
         nb_out_q    <= 1'b1;
         na_st_q     <= 1'b1;
         nb_st_q     <= 1'b1;
         storedata_q <= 4'h0;
         carry_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Strobes and DONE are single-cycle pulses; they default inactive every edge.
         na_out_q <= 1'b1;
         nb_out_q <= 1'b1;
         na_st_q  <= 1'b1;
         nb_st_q  <= 1'b1;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (CMD_VALID) begin
                  src_q  <= CMD_SRC;
                  dst_q  <= CMD_DST;
                  add_q  <= CMD_ADD;
                  imm_q  <= CMD_IMM;
                  opnd_q <= (CMD_SRC == SrcIn) ? IN_PORT : CMD_IMM;
                  if ((CMD_SRC == SrcA) || (CMD_SRC == SrcB)) begin
                     state_q  <= StRead;
                     na_out_q <= (CMD_SRC != SrcA);
                     nb_out_q <= (CMD_SRC != SrcB);
                  end else begin
                     state_q <= StCalc;
                  end
               end
            end
            StRead: begin
               opnd_q  <= (src_q == SrcA) ? A_LOADDATA : B_LOADDATA;
               state_q <= StCalc;
            end
            StCalc: begin
               carry_q <= add_applied & sum[4];
               if (dst_q != 2'b00) begin
                  state_q     <= StWrite;
                  storedata_q <= sum[3:0];
                  na_st_q     <= ~dst_q[0];
                  nb_st_q     <= ~dst_q[1];
               end else begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
               end
            end
            StWrite: begin
               state_q <= StFin;
               done_q  <= 1'b1;
            end
            StFin: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign CMD_READY = (state_q == StIdle);
   assign nA_OUT    = na_out_q;
   assign nB_OUT    = nb_out_q;
   assign nA_ST     = na_st_q;
   assign nB_ST     = nb_st_q;
   assign STOREDATA = storedata_q;
   assign CARRY     = carry_q;
   assign DONE      = done_q;

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  system clock (50 MHz), all state on rising edge.
REQ-002 SHALL have port RST  input  1  reset; one clock, RST is asynchronous and active-low.
REQ-003 SHALL have port CMD_VALID  input  1  command request.
REQ-004 SHALL have port CMD_READY  output  1  high only in IDLE; command accepted on edge with VALID&READY.
REQ-005 SHALL have port CMD_SRC  input  2  00 immediate, 01 register A, 10 register B, 11 IN_PORT.
REQ-006 SHALL have port CMD_DST  input  2  00 none, 01 A, 10 B, 11 both A and B.
REQ-007 SHALL have port CMD_ADD  input  1  add CMD_IMM to the source operand.
REQ-008 SHALL have port CMD_IMM  input  4  immediate operand.
REQ-009 SHALL have port IN_PORT  input  4  external input value.
REQ-010 SHALL have ports A_LOADDATA, B_LOADDATA  input  4  register read data.
REQ-011 SHALL have ports nA_OUT, nB_OUT  output  1  active-low register read enable.
REQ-012 SHALL have ports nA_ST, nB_ST  output  1  active-low register store strobe.
REQ-013 SHALL have port STOREDATA  output  4  write data to registers.
REQ-014 SHALL have port CARRY  output  1  carry flag.
REQ-015 SHALL have port DONE  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM IDLE, READ, CALC, WRITE, FIN; all outputs registered except CMD_READY (= state is IDLE).
REQ-017 SHALL latch CMD_SRC/DST/ADD/IMM and IN_PORT on acceptance; later input changes have no effect.
REQ-018 SHALL go IDLE->READ for SRC 01/10, IDLE->CALC for SRC 00/11.
REQ-019 SHALL in READ drive the selected nX_OUT low for exactly one cycle, all other strobes high.
REQ-020 SHALL in CALC sample the selected LOADDATA (value present during READ cycle's following edge) and form 5-bit sum = operand + (ADD ? IMM : 0).
REQ-021 SHALL treat SRC=00 operand as IMM with ADD ignored (value IMM, no addition).
REQ-022 SHALL go CALC->WRITE if DST!=00, else CALC->FIN.
REQ-023 SHALL in WRITE hold STOREDATA=sum[3:0] stable and drive nA_ST and/or nB_ST low for exactly one cycle; DST=11 lowers both in the same cycle.
REQ-024 SHALL update CARRY at CALC->next: sum[4] when ADD applied, else 0; CARRY holds between commands.
REQ-025 SHALL in FIN pulse DONE high one cycle, then return to IDLE.
REQ-026 SHALL give acceptance-edge-to-DONE latency: 4 cycles register source with write, 3 immediate/IN_PORT with write, one fewer when DST=00.
REQ-027 SHALL ignore CMD_VALID outside IDLE; no queuing.
REQ-028 SHALL allow SRC equal to DST (e.g., A->A, A+IMM->A); read completes before store.
REQ-029 SHALL wrap sum modulo 16 (e.g., F+1 = 0, CARRY=1).
REQ-030 SHALL never assert a nX_OUT and a nX_ST low in the same cycle.

Reset
REQ-031 SHALL on RST low immediately (no clock) force IDLE, nA_OUT=nB_OUT=nA_ST=nB_ST=1, STOREDATA=0, CARRY=0, DONE=0.
REQ-032 SHALL abort any in-flight command on reset mid-operation; no strobe may glitch low during or after reset; first command accepted on first edge after RST high.

Configuration
REQ-033 SHALL with macro REG_XFER_CARRY_EN defined implement CMD_ADD addition and CARRY per REQ-020/024.
REQ-034 SHALL without REG_XFER_CARRY_EN ignore CMD_ADD (sum = operand), tie CARRY to 0; FSM timing unchanged.

Verification
REQ-035 SHALL cover: reset, SRC=00 IMM=A DST=10 -> nB_ST low 1 cycle with STOREDATA=A, DONE 3 cycles after accept.
REQ-036 SHALL cover: A_LOADDATA=5, SRC=01 DST=10 -> nA_OUT low 1 cycle, then nB_ST low with STOREDATA=5, DONE at +4.
REQ-037 SHALL cover: B_LOADDATA=F, SRC=10 ADD IMM=1 DST=10 -> STOREDATA=0, CARRY=1; following plain MOV clears CARRY=0.
REQ-038 SHALL cover: IN_PORT=3 SRC=11 DST=11 -> nA_ST and nB_ST low same cycle, STOREDATA=3; CMD_VALID while busy ignored.
REQ-039 SHALL cover: RST low during WRITE -> all strobes high at once, no store pulse, CMD_READY=1; DST=00 command -> no strobes, DONE at +3.
